// File: rtl/register_file_pkg.sv
// Shared constants for the register file: default geometry and the register
// numbers the CPU control logic refers to by name.
package register_file_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;

    localparam int unsigned RegZero = 0;
    localparam int unsigned RegAcc  = 1;
    localparam int unsigned RegTmp  = 2;
    localparam int unsigned RegLink = 3;

endpackage

// File: rtl/register_read_port.sv
// One registered read port: address decode, out-of-range zeroing, optional
// write-to-read forwarding and the clock-enabled output register.
module register_read_port #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clock_i,
    input  logic              clear_i,
    input  logic              read_enable_i,
    input  logic [ADDR_W-1:0] read_address_i,
    input  logic [WIDTH-1:0]  regs_i [DEPTH],
    input  logic              write_valid_i,
    input  logic [ADDR_W-1:0] write_address_i,
    input  logic [WIDTH-1:0]  write_data_i,
    output logic [WIDTH-1:0]  q_o
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (read_enable_i) begin
            // Unmatched (out-of-range) addresses fall through to zero.
            q_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (read_address_i == ADDR_W'(i) && !(ZERO_REG && i == 0)) begin
                    q_d = regs_i[i];
                end
            end
            // write_valid_i already excludes out-of-range and hardwired-zero targets.
            if (BYPASS && write_valid_i && write_address_i == read_address_i) begin
                q_d = write_data_i;
            end
        end
    end

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/register_file.sv
// Parameterised register file with one write port and two registered read
// ports; asynchronous clear wipes storage and outputs.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              input_clear,
    input  logic              input_write_enable,
    input  logic [ADDR_W-1:0] input_write_address,
    input  logic [WIDTH-1:0]  input_d,
    input  logic              input_read_enable,
    input  logic [ADDR_W-1:0] input_read_address_a,
    input  logic [ADDR_W-1:0] input_read_address_b,
    output logic [WIDTH-1:0]  output_q_a,
    output logic [WIDTH-1:0]  output_q_b
);

    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             write_valid;

    always_comb begin
        write_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (input_write_address == ADDR_W'(i)) begin
                write_valid = input_write_enable;
            end
        end
        if (ZERO_REG && input_write_address == '0) begin
            write_valid = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (write_valid && input_write_address == ADDR_W'(i)) begin
                regs_d[i] = input_d;
            end
        end
    end

    always_ff @(posedge clock or posedge input_clear) begin
        if (input_clear) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    register_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_a (
        .clock_i        (clock),
        .clear_i        (input_clear),
        .read_enable_i  (input_read_enable),
        .read_address_i (input_read_address_a),
        .regs_i         (regs_q),
        .write_valid_i  (write_valid),
        .write_address_i(input_write_address),
        .write_data_i   (input_d),
        .q_o            (output_q_a)
    );

    register_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_b (
        .clock_i        (clock),
        .clear_i        (input_clear),
        .read_enable_i  (input_read_enable),
        .read_address_i (input_read_address_b),
        .regs_i         (regs_q),
        .write_valid_i  (write_valid),
        .write_address_i(input_write_address),
        .write_data_i   (input_d),
        .q_o            (output_q_b)
    );

endmodule

// File: tb/tb_register_file.sv
// Three register_file configurations driven by shared stimulus and checked
// against an array-based reference model.
module tb_register_file;

    logic        clock = 1'b0;
    logic        input_clear = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [2:0]  wa = '0;
    logic [2:0]  ra = '0;
    logic [2:0]  rb = '0;
    logic [15:0] d = '0;

    logic [7:0]  q0a, q0b, q1a, q1b;
    logic [15:0] q2a, q2b;
    logic [15:0] act_a [3];
    logic [15:0] act_b [3];

    // Instance 0: defaults. 1: DEPTH=3, no bypass, hardwired zero. 2: wide.
    int          dep   [3] = '{4, 3, 8};
    int          amask [3] = '{3, 3, 7};
    logic [15:0] wmask [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    bit          zr    [3] = '{1'b0, 1'b1, 1'b0};

    logic [15:0] mem   [3][8];
    logic [15:0] exp_a [3];
    logic [15:0] exp_b [3];
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    register_file u_dut0 (
        .clock(clock), .input_clear(input_clear), .input_write_enable(we),
        .input_write_address(wa[1:0]), .input_d(d[7:0]), .input_read_enable(re),
        .input_read_address_a(ra[1:0]), .input_read_address_b(rb[1:0]),
        .output_q_a(q0a), .output_q_b(q0b)
    );

    register_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut1 (
        .clock(clock), .input_clear(input_clear), .input_write_enable(we),
        .input_write_address(wa[1:0]), .input_d(d[7:0]), .input_read_enable(re),
        .input_read_address_a(ra[1:0]), .input_read_address_b(rb[1:0]),
        .output_q_a(q1a), .output_q_b(q1b)
    );

    register_file #(.WIDTH(16), .DEPTH(8)) u_dut2 (
        .clock(clock), .input_clear(input_clear), .input_write_enable(we),
        .input_write_address(wa), .input_d(d), .input_read_enable(re),
        .input_read_address_a(ra), .input_read_address_b(rb),
        .output_q_a(q2a), .output_q_b(q2b)
    );

    always_comb begin
        act_a[0] = {8'h00, q0a};
        act_b[0] = {8'h00, q0b};
        act_a[1] = {8'h00, q1a};
        act_b[1] = {8'h00, q1b};
        act_a[2] = q2a;
        act_b[2] = q2b;
    end

    function automatic logic [15:0] model_rd(int i, int a);
        int w = int'(wa) & amask[i];
        if (a >= dep[i] || (zr[i] && a == 0)) return 16'h0000;
        if (we && w == a && byp[i]) return d & wmask[i];
        return mem[i][a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 8; j++) mem[i][j] = 16'h0000;
            exp_a[i] = 16'h0000;
            exp_b[i] = 16'h0000;
        end
    endtask

    task automatic model_edge();
        if (input_clear) return;
        for (int i = 0; i < 3; i++) begin
            int w = int'(wa) & amask[i];
            if (re) begin
                exp_a[i] = model_rd(i, int'(ra) & amask[i]);
                exp_b[i] = model_rd(i, int'(rb) & amask[i]);
            end
            if (we && w < dep[i] && !(zr[i] && w == 0)) mem[i][w] = d & wmask[i];
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic w_en, input int w_addr, input logic [15:0] w_data,
                        input logic r_en, input int r_a, input int r_b);
        we = w_en;
        wa = 3'(w_addr);
        d  = w_data;
        re = r_en;
        ra = 3'(r_a);
        rb = 3'(r_b);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== 16'h0 || act_b[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: q_a=%h q_b=%h want 0000", i, act_a[i],
                         act_b[i]);
            end
        end
        input_clear = 1'b0;
    endtask

    task automatic test_write_read();
        step(1'b1, 1, 16'h005A, 1'b0, 0, 0);
        step(1'b1, 2, 16'h00A5, 1'b0, 0, 0);
        step(1'b0, 0, 16'h0000, 1'b1, 1, 2);
        checks++;
        if (act_a[0] !== 16'h005A || act_b[0] !== 16'h00A5) begin
            errors++;
            $display("FAIL write_read: q_a=%h q_b=%h want 005a 00a5", act_a[0], act_b[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL write_read dut%0d: got %h/%h want %h/%h", i, act_a[i], act_b[i],
                         exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 3, 16'h0011, 1'b0, 0, 0);
        step(1'b1, 3, 16'h0022, 1'b1, 3, 3);
        checks++;
        if (act_a[0] !== 16'h0022 || act_b[0] !== 16'h0022) begin
            errors++;
            $display("FAIL bypass_on: q_a=%h q_b=%h want 0022", act_a[0], act_b[0]);
        end
        step(1'b1, 2, 16'h0033, 1'b0, 0, 0);
        step(1'b1, 2, 16'h0044, 1'b1, 2, 1);
        checks++;
        if (act_a[1] !== 16'h0033 || act_a[0] !== 16'h0044) begin
            errors++;
            $display("FAIL bypass_off: dut1 q_a=%h want 0033, dut0 q_a=%h want 0044",
                     act_a[1], act_a[0]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL bypass dut%0d: got %h/%h want %h/%h", i, act_a[i], act_b[i],
                         exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_hold();
        step(1'b0, 0, 16'h0000, 1'b1, 1, 1);
        step(1'b1, 1, 16'h0000, 1'b0, 1, 1);
        step(1'b0, 0, 16'h0000, 1'b0, 1, 1);
        checks++;
        if (act_a[0] !== 16'h005A) begin
            errors++;
            $display("FAIL hold: q_a=%h want 005a", act_a[0]);
        end
        step(1'b0, 0, 16'h0000, 1'b1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== exp_a[i] || act_a[i] !== 16'h0000) begin
                errors++;
                $display("FAIL hold_release dut%0d: q_a=%h want %h", i, act_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_zero_reg();
        step(1'b1, 0, 16'h00FF, 1'b0, 0, 0);
        step(1'b1, 3, 16'h00FF, 1'b0, 0, 0);
        step(1'b1, 0, 16'h00FF, 1'b1, 0, 3);
        checks++;
        if (act_a[1] !== 16'h0000 || act_b[1] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_reg: q_a=%h q_b=%h want 0000", act_a[1], act_b[1]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL zero_reg dut%0d: got %h/%h want %h/%h", i, act_a[i], act_b[i],
                         exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_width();
        step(1'b1, 7, 16'hBEEF, 1'b0, 0, 0);
        step(1'b0, 0, 16'h0000, 1'b1, 7, 7);
        checks++;
        if (act_a[2] !== 16'hBEEF || act_b[2] !== 16'hBEEF) begin
            errors++;
            $display("FAIL width: q_a=%h q_b=%h want beef", act_a[2], act_b[2]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL width dut%0d: got %h/%h want %h/%h", i, act_a[i], act_b[i],
                         exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_clear();
        for (int j = 0; j < 8; j++) step(1'b1, j, 16'hFFFF, 1'b0, 0, 0);
        step(1'b0, 0, 16'h0000, 1'b1, 1, 2);
        // Raise clear between edges with a write pending; it must act at once.
        we = 1'b1; wa = 3'd1; d = 16'h0077; re = 1'b1; ra = 3'd1; rb = 3'd1;
        #2 input_clear = 1'b1;
        model_clear();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_a[i] !== 16'h0 || act_b[i] !== 16'h0) begin
                errors++;
                $display("FAIL clear_async dut%0d: q_a=%h q_b=%h want 0000", i, act_a[i],
                         act_b[i]);
            end
        end
        @(posedge clock);
        model_edge();
        @(negedge clock);
        checks++;
        if (act_a[0] !== 16'h0 || act_a[2] !== 16'h0) begin
            errors++;
            $display("FAIL clear_hold: q_a0=%h q_a2=%h want 0000", act_a[0], act_a[2]);
        end
        input_clear = 1'b0;
        for (int j = 0; j < 8; j += 2) begin
            step(1'b0, 0, 16'h0000, 1'b1, j, j + 1);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_a[i] !== 16'h0 || act_b[i] !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_regs dut%0d addr %0d: got %h/%h want 0000", i, j,
                             act_a[i], act_b[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom), int'($urandom_range(7)), 16'($urandom), 1'($urandom),
                 int'($urandom_range(7)), int'($urandom_range(7)));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_a[i] !== exp_a[i] || act_b[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL random cycle %0d dut%0d: got %h/%h want %h/%h", n, i,
                             act_a[i], act_b[i], exp_a[i], exp_b[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_hold();
        test_zero_reg();
        test_width();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
